keypad_scan_ctrl: RTL and testbench

Scan controller for the 4x4 matrix keypad. Drives one-hot row strobes and samples column returns, debounces both press and release, and rejects multi-key (ghost) patterns. Encodes each accepted press as a 4-bit key code and buffers it in a small FIFO with a valid/ready handshake to the downstream consumer (MCU interface / display logic).

---
 rtl/keypad_scan_ctrl.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scanner with press/release debounce, ghost rejection and key-code FIFO.
// Latency: 2-cycle column synchronizer; a code is pushed DEBOUNCE edges after the scan sample and is visible one cycle later.
// Backpressure: o_key_valid/i_key_ready handshake on the FIFO head; a push into a full FIFO without a pop is dropped and sets sticky o_overflow.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV   = 4,
    parameter int DEBOUNCE   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_col,
    output logic [3:0] o_row,
    output logic [3:0] o_key_code,
    output logic       o_key_valid,
    input  logic       i_key_ready,
    output logic       o_pressed,
    output logic       o_overflow
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE - 1);
    localparam logic [AW:0]   FIFO_FULL  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_SCAN = 2'd0,
        ST_DEB  = 2'd1,
        ST_HELD = 2'd2,
        ST_REL  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Column synchronizer and scan datapath
    logic [3:0]    r_col_m;
    logic [3:0]    r_col_s;
    logic [1:0]    r_row_idx;
    logic [DW-1:0] r_dwell;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_cap;

    // Key-code FIFO
    logic [3:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;

    // Decoded conditions
    logic       w_col_zero;
    logic       w_col_match;
    logic       w_sample;
    logic       w_cnt_done;
    logic       w_cap_onehot;
    logic [1:0] w_col_idx;
    logic [3:0] w_new_code;

    // Datapath controls from the FSM output decode
    logic w_dwell_inc;
    logic w_dwell_clr;
    logic w_row_adv;
    logic w_row_home;
    logic w_cnt_inc;
    logic w_cnt_clr;
    logic w_cap_ld;
    logic w_push_req;

    // FIFO handshake
    logic w_pop;
    logic w_full;
    logic w_push;

    // Two-flop synchronizer: the column lines are asynchronous to the clock
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_col_m <= 4'b0;
            r_col_s <= 4'b0;
        end else begin
            r_col_m <= i_col;
            r_col_s <= r_col_m;
        end
    end

    // Condition decode shared by next-state and output logic
    always_comb begin
        w_col_zero   = (r_col_s == 4'b0);
        w_col_match  = (r_col_s == r_cap);
        w_sample     = (r_dwell == DWELL_LAST);
        w_cnt_done   = (r_cnt == CNT_LAST);
        // More than one set column bit means a ghost/multi-key pattern
        w_cap_onehot = (r_cap != 4'b0) && ((r_cap & (r_cap - 4'd1)) == 4'b0);
    end

    // Column index of the captured one-hot pattern
    always_comb begin
        w_col_idx = 2'd0;
        case (r_cap)
            4'b0001: w_col_idx = 2'd0;
            4'b0010: w_col_idx = 2'd1;
            4'b0100: w_col_idx = 2'd2;
            4'b1000: w_col_idx = 2'd3;
            default: w_col_idx = 2'd0;
        endcase
    end

    assign w_new_code = {r_row_idx, w_col_idx};

    // FSM state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_SCAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SCAN: begin
                if (w_sample && !w_col_zero) begin
                    w_state_nxt = ST_DEB;
                end
            end
            ST_DEB: begin
                if (!w_col_match) begin
                    w_state_nxt = ST_SCAN;
                end else if (w_cnt_done) begin
                    w_state_nxt = ST_HELD;
                end
            end
            ST_HELD: begin
                // Column changes while still nonzero are ignored: no auto-repeat
                if (w_col_zero) begin
                    w_state_nxt = ST_REL;
                end
            end
            ST_REL: begin
                if (!w_col_zero) begin
                    w_state_nxt = ST_HELD;
                end else if (w_cnt_done) begin
                    w_state_nxt = ST_SCAN;
                end
            end
            default: w_state_nxt = ST_SCAN;
        endcase
    end

    // FSM output decode: datapath controls and the pressed flag
    always_comb begin
        w_dwell_inc = 1'b0;
        w_dwell_clr = 1'b0;
        w_row_adv   = 1'b0;
        w_row_home  = 1'b0;
        w_cnt_inc   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cap_ld    = 1'b0;
        w_push_req  = 1'b0;
        o_pressed   = (r_state == ST_HELD) || (r_state == ST_REL);
        case (r_state)
            ST_SCAN: begin
                if (w_sample) begin
                    w_dwell_clr = 1'b1;
                    if (w_col_zero) begin
                        w_row_adv = 1'b1;
                    end else begin
                        // Row holds while the press is debounced
                        w_cap_ld  = 1'b1;
                        w_cnt_clr = 1'b1;
                    end
                end else begin
                    w_dwell_inc = 1'b1;
                end
            end
            ST_DEB: begin
                if (!w_col_match) begin
                    w_row_adv   = 1'b1;
                    w_dwell_clr = 1'b1;
                end else if (!w_cnt_done) begin
                    w_cnt_inc = 1'b1;
                end else begin
                    // Ghost patterns enter HELD so they are waited out, but never coded
                    w_push_req = w_cap_onehot;
                end
            end
            ST_HELD: begin
                if (w_col_zero) begin
                    w_cnt_clr = 1'b1;
                end
            end
            ST_REL: begin
                if (w_col_zero) begin
                    if (w_cnt_done) begin
                        w_row_home  = 1'b1;
                        w_dwell_clr = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            default: begin
                w_dwell_clr = 1'b1;
            end
        endcase
    end

    // Scan datapath: row index, dwell counter, debounce counter, captured columns
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_row_idx <= 2'd0;
            r_dwell   <= '0;
            r_cnt     <= '0;
            r_cap     <= 4'b0;
        end else begin
            if (w_row_home) begin
                r_row_idx <= 2'd0;
            end else if (w_row_adv) begin
                r_row_idx <= r_row_idx + 2'd1;
            end
            if (w_dwell_clr) begin
                r_dwell <= '0;
            end else if (w_dwell_inc) begin
                r_dwell <= r_dwell + DW'(1);
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_cap_ld) begin
                r_cap <= r_col_s;
            end
        end
    end

    assign o_row = 4'b0001 << r_row_idx;

    // FIFO handshake: a pop in the same cycle frees room for a push into a full FIFO
    assign w_pop  = o_key_valid && i_key_ready;
    assign w_full = (r_count == FIFO_FULL);
    assign w_push = w_push_req && (!w_full || w_pop);

    // FIFO storage; contents are masked by the count so no reset is needed
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_new_code;
        end
    end

    // FIFO pointers, occupancy count and sticky overflow flag
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_req && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_key_valid = (r_count != '0);
    assign o_key_code  = o_key_valid ? r_mem[r_rd_ptr] : 4'b0;
    assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
module tb_keypad_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] kc;
    logic       kv;
    logic       kr;
    logic       pr;
    logic       ov;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE(8), .FIFO_DEPTH(4)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_col       (col),
        .o_row       (row),
        .o_key_code  (kc),
        .o_key_valid (kv),
        .i_key_ready (kr),
        .o_pressed   (pr),
        .o_overflow  (ov)
    );

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [3:0] exp_q [$];

    // Keypad model: which key is held (row index and column mask)
    logic       key_on;
    logic [1:0] key_row;
    logic [3:0] key_mask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_col();
        logic [3:0] sel;
        sel = 4'b0001 << key_row;
        if (key_on && (row == sel)) col = key_mask;
        else col = 4'b0;
    endtask

    // One clock: score any handshake completing on the coming edge, then re-drive the matrix
    task automatic tick();
        if (kv && kr) begin
            pops++;
            if (exp_q.size() == 0) begin
                chk("pop_with_empty_scoreboard", exp_q.size(), 1);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                chk("pop_code", kc, e);
            end
        end
        @(posedge clk);
        #1;
        set_col();
    endtask

    task automatic wait_pr(input logic lvl, input string tag);
        int n = 0;
        while (pr !== lvl && n < 200) begin
            tick();
            n++;
        end
        chk(tag, pr, lvl);
    endtask

    task automatic press(input logic [1:0] r, input logic [3:0] m);
        key_row  = r;
        key_mask = m;
        key_on   = 1'b1;
        set_col();
    endtask

    task automatic release_key(input string tag);
        key_on = 1'b0;
        set_col();
        wait_pr(1'b0, tag);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_row"}, row, 4'b0001);
        chk({tag, "_valid"}, kv, 0);
        chk({tag, "_code"}, kc, 0);
        chk({tag, "_pressed"}, pr, 0);
        chk({tag, "_overflow"}, ov, 0);
    endtask

    logic [1:0] fr [5];
    logic [3:0] fm [5];
    logic [3:0] fc [5];

    initial begin
        int n;
        int pops0;
        logic saw;
        logic [3:0] er;

        rst = 1'b1; col = 4'b0; kr = 1'b1;
        key_on = 1'b0; key_row = 2'd0; key_mask = 4'b0;
        fr[0] = 2'd0; fm[0] = 4'b0001; fc[0] = 4'h0;
        fr[1] = 2'd1; fm[1] = 4'b0010; fc[1] = 4'h5;
        fr[2] = 2'd2; fm[2] = 4'b0100; fc[2] = 4'hA;
        fr[3] = 2'd3; fm[3] = 4'b1000; fc[3] = 4'hF;
        fr[4] = 2'd1; fm[4] = 4'b0100; fc[4] = 4'h6;

        // Reset asserted mid-scan, then the idle scan sequence
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_midscan");
        @(posedge clk);
        #1 rst = 1'b0;
        set_col();
        for (int i = 0; i <= 16; i++) begin
            if (i % 4 == 0) begin
                er = 4'b0001 << ((i / 4) % 4);
                chk("scan_row", row, er);
            end
            if (i < 16) tick();
        end
        chk("scan_valid", kv, 0);

        // Single press row2/col1
        pops0 = pops;
        exp_q.push_back(4'h9);
        press(2'd2, 4'b0010);
        wait_pr(1'b1, "single_pressed");
        chk("single_valid_at_push", kv, 1);
        repeat (60) tick();
        chk("single_still_pressed", pr, 1);
        chk("single_one_pop", pops - pops0, 1);
        key_on = 1'b0;
        set_col();
        n = 0;
        while (pr && n < 40) begin
            tick();
            n++;
        end
        chk("release_cycles", n, 11);
        chk("release_row", row, 4'b0001);

        // Bouncing contact on row0/col3: never accepted
        key_row = 2'd0; key_mask = 4'b1000; key_on = 1'b0; saw = 1'b0;
        for (int i = 0; i < 36; i++) begin
            if (i % 3 == 0) begin
                key_on = ~key_on;
                set_col();
            end
            tick();
            saw |= pr;
        end
        key_on = 1'b0;
        set_col();
        repeat (20) tick();
        chk("bounce_no_press", saw, 0);
        chk("bounce_no_valid", kv, 0);
        exp_q.push_back(4'h3);
        press(2'd0, 4'b1000);
        wait_pr(1'b1, "stable_pressed");
        repeat (4) tick();
        chk("stable_popped", exp_q.size(), 0);
        release_key("stable_released");

        // Ghost pattern on row1
        press(2'd1, 4'b0011);
        wait_pr(1'b1, "ghost_pressed");
        repeat (20) tick();
        chk("ghost_no_valid", kv, 0);
        release_key("ghost_released");
        chk("ghost_no_valid_after", kv, 0);

        // FIFO overflow with the consumer stalled
        kr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(fc[i]);
            press(fr[i], fm[i]);
            wait_pr(1'b1, "fifo_pressed");
            repeat (3) tick();
            release_key("fifo_released");
            if (i == 3) chk("fifo_no_overflow_at_full", ov, 0);
        end
        chk("fifo_overflow", ov, 1);
        chk("fifo_valid", kv, 1);
        chk("fifo_head", kc, 4'h0);
        kr = 1'b1;
        repeat (8) tick();
        chk("fifo_drained_valid", kv, 0);
        chk("fifo_drained_all", exp_q.size(), 0);
        chk("fifo_overflow_sticky", ov, 1);

        // Reset during DEBOUNCE
        rst = 1'b1;
        tick();
        rst = 1'b0;
        press(2'd0, 4'b0001);
        repeat (7) tick();
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_debounce");
        key_on = 1'b0;
        set_col();
        tick();
        rst = 1'b0;
        repeat (30) tick();
        chk("rst_debounce_no_code", kv, 0);
        chk("rst_debounce_idle", pr, 0);

        // Reset during HELD with the code still queued
        kr = 1'b0;
        press(2'd0, 4'b0001);
        exp_q.push_back(4'h0);
        repeat (20) tick();
        chk("held_pressed", pr, 1);
        chk("held_valid", kv, 1);
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk_reset_outputs("rst_held");
        key_on = 1'b0;
        set_col();
        tick();
        rst = 1'b0;
        kr = 1'b1;
        repeat (30) tick();
        chk("rst_held_no_code", kv, 0);
        chk("rst_held_idle", pr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
